// File: rtl/key_debounce_quad.sv
// key_debounce_quad: four independent pushbutton/switch debouncers.
// Each channel has a 2-FF synchronizer, a stability counter and a
// registered stable level. A new level must be seen on N consecutive
// synchronized cycles before key_out takes it, where
// N = (CLK_FREQ_HZ/1000)*DEBOUNCE_MS.
// Optional feature macro: DEBOUNCE_PULSE_EN. When it is defined, the
// ports key_rise/key_fall carry one-cycle edge pulses of key_out.
// When it is undefined, those ports and their edge registers do not exist.
module key_debounce_quad #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [3:0] key_out
`ifdef DEBOUNCE_PULSE_EN
  ,
  output logic [3:0] key_rise,
  output logic [3:0] key_fall
`endif
);

  localparam int N     = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A debounce window shorter than two cycles cannot reject anything.
  if (N < 2) begin : g_bad_window
    $error("key_debounce_quad: N = %0d, must be >= 2", N);
  end

  logic [3:0]            sync1_q;
  logic [3:0]            sync2_q;
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0][CNT_W-1:0] cnt_d;
  logic [3:0]            key_out_q;
  logic [3:0]            key_out_d;

  // Per-channel stability counter: clear on agreement, accept after N mismatches.
  always_comb begin
    key_out_d = key_out_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == key_out_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        key_out_d[i] = sync2_q[i];
        cnt_d[i]     = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Synchronizers, counters and stable levels; reset clears all progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 4'b0000;
      sync2_q   <= 4'b0000;
      cnt_q     <= {4*CNT_W{1'b0}};
      key_out_q <= 4'b0000;
    end else begin
      sync1_q   <= key_in;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      key_out_q <= key_out_d;
    end
  end

  assign key_out = key_out_q;

`ifdef DEBOUNCE_PULSE_EN
  logic [3:0] key_out_dly_q;

  // One-cycle delayed copy of key_out for edge detection; zero at reset so
  // release never produces a spurious pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_out_dly_q <= 4'b0000;
    end else begin
      key_out_dly_q <= key_out_q;
    end
  end

  assign key_rise = key_out_q & ~key_out_dly_q;
  assign key_fall = ~key_out_q & key_out_dly_q;
`endif

endmodule

// File: tb/tb_key_debounce_quad.sv
// Bench for key_debounce_quad with N = 4 (1 kHz clock, 4 ms window).
// Stimulus pushes expected values, tagged with the clock edge they are due
// on, into a scoreboard queue; a negedge monitor pops and compares them.
module tb_key_debounce_quad;

  localparam int SIG_OUT  = 0;
  localparam int SIG_RISE = 1;
  localparam int SIG_FALL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in = 4'b0000;
  logic [3:0] key_out;
`ifdef DEBOUNCE_PULSE_EN
  logic [3:0] key_rise;
  logic [3:0] key_fall;
`endif

  int n_checks   = 0;
  int n_failures = 0;
  int edge_cnt   = 0;

  typedef struct {
    int         due;
    int         sig;
    logic [3:0] mask;
    logic [3:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  logic [3:0] obs;

  key_debounce_quad #(
    .CLK_FREQ_HZ(1000),
    .DEBOUNCE_MS(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_in  (key_in),
    .key_out (key_out)
`ifdef DEBOUNCE_PULSE_EN
    ,
    .key_rise(key_rise),
    .key_fall(key_fall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  task automatic push(input int due, input int sig, input logic [3:0] mask,
                      input logic [3:0] val, input string tag);
    exp_t e;
    e.due = due; e.sig = sig; e.mask = mask; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_rng(input int lo, input int hi, input int sig, input logic [3:0] mask,
                          input logic [3:0] val, input string tag);
    for (int d = lo; d <= hi; d++) push(d, sig, mask, val, tag);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation whose edge has arrived.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= edge_cnt) begin
        case (sb[i].sig)
`ifdef DEBOUNCE_PULSE_EN
          SIG_RISE: obs = key_rise;
          SIG_FALL: obs = key_fall;
`endif
          default:  obs = key_out;
        endcase
        check_eq(sb[i].tag, {28'd0, obs & sb[i].mask}, {28'd0, sb[i].val & sb[i].mask});
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;

    // Test 1: reset held with all keys high, then release.
    rst = 1'b1;
    key_in = 4'hF;
    step(3);
    push(edge_cnt, SIG_OUT, 4'hF, 4'h0, "t1_in_rst");
`ifdef DEBOUNCE_PULSE_EN
    push(edge_cnt, SIG_RISE, 4'hF, 4'h0, "t1_rise_rst");
    push(edge_cnt, SIG_FALL, 4'hF, 4'h0, "t1_fall_rst");
`endif
    step(1);
    rst = 1'b0;
    k = edge_cnt;
    push_rng(k, k + 5, SIG_OUT, 4'hF, 4'h0, "t1_wait");
    push(k + 6, SIG_OUT, 4'hF, 4'hF, "t1_accept");
`ifdef DEBOUNCE_PULSE_EN
    push_rng(k, k + 5, SIG_RISE, 4'hF, 4'h0, "t1_no_rise_early");
`endif
    step(7);

    // All keys back to 0 so the following tests start from a known level.
    k = edge_cnt;
    key_in = 4'h0;
    push(k + 5, SIG_OUT, 4'hF, 4'hF, "t1b_hold");
    push(k + 6, SIG_OUT, 4'hF, 4'h0, "t1b_release");
    step(7);

    // Test 2: channel 0 high for only 3 cycles is rejected.
    k = edge_cnt;
    push_rng(k, k + 8, SIG_OUT, 4'h1, 4'h0, "t2_short_glitch");
    key_in = 4'h1;
    step(3);
    key_in = 4'h0;
    step(6);

    // Test 3: channel 1 high for exactly 4 cycles is accepted, then released.
    k = edge_cnt;
    push_rng(k, k + 5, SIG_OUT, 4'h2, 4'h0, "t3_before");
    push_rng(k + 6, k + 9, SIG_OUT, 4'h2, 4'h2, "t3_accepted");
    push(k + 10, SIG_OUT, 4'h2, 4'h0, "t3_released");
    key_in = 4'h2;
    step(4);
    key_in = 4'h0;
    step(7);

    // Test 4: channel 2 bounces 1,0,1,0 then settles at 1.
    k = edge_cnt;
    push_rng(k, k + 9, SIG_OUT, 4'h4, 4'h0, "t4_bounce");
    push_rng(k + 10, k + 12, SIG_OUT, 4'h4, 4'h4, "t4_settled");
    key_in = 4'h4; step(1);
    key_in = 4'h0; step(1);
    key_in = 4'h4; step(1);
    key_in = 4'h0; step(1);
    key_in = 4'h4; step(9);

    // Test 5: channel 3 rises then falls; edge pulses when enabled.
    k = edge_cnt;
    push_rng(k, k + 5, SIG_OUT, 4'h8, 4'h0, "t5_before_rise");
    push_rng(k + 6, k + 8, SIG_OUT, 4'h8, 4'h8, "t5_high");
`ifdef DEBOUNCE_PULSE_EN
    push_rng(k, k + 5, SIG_RISE, 4'hF, 4'h0, "t5_rise_idle");
    push(k + 6, SIG_RISE, 4'hF, 4'h8, "t5_rise_pulse");
    push_rng(k + 7, k + 8, SIG_RISE, 4'hF, 4'h0, "t5_rise_done");
    push_rng(k, k + 8, SIG_FALL, 4'hF, 4'h0, "t5_fall_idle");
`endif
    key_in = 4'hC;
    step(8);
    k = edge_cnt;
    push_rng(k, k + 5, SIG_OUT, 4'h8, 4'h8, "t5_hold_high");
    push(k + 6, SIG_OUT, 4'h8, 4'h0, "t5_low");
`ifdef DEBOUNCE_PULSE_EN
    push_rng(k, k + 5, SIG_FALL, 4'hF, 4'h0, "t5_fall_wait");
    push(k + 6, SIG_FALL, 4'hF, 4'h8, "t5_fall_pulse");
    push(k + 7, SIG_FALL, 4'hF, 4'h0, "t5_fall_done");
    push_rng(k, k + 7, SIG_RISE, 4'hF, 4'h0, "t5_rise_quiet");
`endif
    key_in = 4'h4;
    step(8);

    // Test 6: async reset while channel 0 is mid-count (cnt=3).
    k = edge_cnt;
    push_rng(k, k + 5, SIG_OUT, 4'hF, 4'h4, "t6_counting");
    key_in = 4'h5;
    step(5);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_async_clr", {28'd0, key_out}, 32'd0);
    step(2);
    rst = 1'b0;
    r = edge_cnt;
    push_rng(r, r + 5, SIG_OUT, 4'hF, 4'h0, "t6_restart");
    push(r + 6, SIG_OUT, 4'hF, 4'h5, "t6_accept");
    step(8);

    check_eq("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
